// File: rtl/bus_elastic_buf.sv
// bus_elastic_buf: valid/ready elastic FIFO placed after the fixed-latency
// bus delay line. The delay line cannot be stalled, so a word that arrives
// while the buffer is full and nothing leaves is dropped, and the sticky
// ovf flag is raised.
// Optional feature macro: BUS_ELASTIC_OVF_CNT_EN adds an 8-bit saturating
// count of dropped words on port ovf_cnt.
module bus_elastic_buf #(
  parameter int BUS_WIDTH = 8,
  parameter int DEPTH     = 4,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic [BUS_WIDTH-1:0] inbus,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [BUS_WIDTH-1:0] outbus,
  output logic [CNT_W-1:0]     level,
  output logic                 full,
  output logic                 empty,
  output logic                 ovf,
  input  logic                 ovf_clr
`ifdef BUS_ELASTIC_OVF_CNT_EN
  ,
  output logic [7:0]           ovf_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [BUS_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     level_q, level_d;
  logic                 ovf_q, ovf_d;
  logic                 pop, push, drop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == DEPTH_C);
  assign out_vld = !empty;
  assign outbus  = mem_q[rd_ptr_q];
  assign level   = level_q;
  assign ovf     = ovf_q;

  // Handshake decode and next-state for pointers, occupancy and overflow flag.
  // A full buffer still accepts a word when the head leaves in the same cycle.
  always_comb begin
    pop      = out_vld && out_rdy;
    push     = in_vld && (!full || pop);
    drop     = in_vld && full && !pop;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + CNT_W'(1);
      2'b01:   level_d = level_q - CNT_W'(1);
      default: level_d = level_q;
    endcase
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  // Control state; reset discards every stored word by zeroing the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array is deliberately left unreset; only accepted words are written.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= inbus;
    end
  end

`ifdef BUS_ELASTIC_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  assign ovf_cnt = ovf_cnt_q;

  // Saturating drop counter; a drop coinciding with a clear counts as the first drop.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop) begin
      if (ovf_clr) begin
        ovf_cnt_d = 8'd1;
      end else if (ovf_cnt_q != 8'hFF) begin
        ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
    end else if (ovf_clr) begin
      ovf_cnt_d = 8'd0;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_q <= 8'd0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_bus_elastic_buf.sv
// Self-checking bench for bus_elastic_buf with a queue scoreboard: words the
// reference model accepts go into expQ, words the DUT hands over go into obsQ.
`timescale 1ns/1ps
module tb_bus_elastic_buf;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_vld;
  logic [W-1:0]  inbus;
  logic          out_vld;
  logic          out_rdy;
  logic [W-1:0]  outbus;
  logic [CW-1:0] level;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          ovf_clr;
`ifdef BUS_ELASTIC_OVF_CNT_EN
  logic [7:0]    ovf_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] expQ[$];
  logic [W-1:0] obsQ[$];
  int   mdlLevel = 0;
  logic mdlOvf   = 1'b0;
  int   mdlCnt   = 0;

  bus_elastic_buf #(.BUS_WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .inbus(inbus),
    .out_vld(out_vld), .out_rdy(out_rdy), .outbus(outbus),
    .level(level), .full(full), .empty(empty), .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef BUS_ELASTIC_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Drive one cycle, advance the model and scoreboard, and step past the edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic c);
    logic mPop, mPush, mDrop;
    in_vld = v; inbus = d; out_rdy = r; ovf_clr = c;
    #1;
    if (rst) begin
      expQ.delete();
      mdlLevel = 0; mdlOvf = 1'b0; mdlCnt = 0;
    end else begin
      mPop  = (mdlLevel != 0) && r;
      mPush = v && ((mdlLevel < D) || mPop);
      mDrop = v && !mPush;
      if (out_vld && out_rdy) obsQ.push_back(outbus);
      if (mPush) expQ.push_back(d);
      mdlLevel = mdlLevel + int'(mPush) - int'(mPop);
      mdlOvf = mDrop ? 1'b1 : (c ? 1'b0 : mdlOvf);
      if (mDrop) mdlCnt = c ? 1 : ((mdlCnt == 255) ? 255 : mdlCnt + 1);
      else if (c) mdlCnt = 0;
    end
    @(posedge clk); #1;
    in_vld = 1'b0; inbus = '0; out_rdy = 1'b0; ovf_clr = 1'b0;
  endtask

  // Reset with junk inputs asserted (must be ignored), then idle.
  task automatic test_reset();
    rst = 1'b1;
    cycle(1'b1, 8'hEE, 1'b1, 1'b1);
    cycle(1'b1, 8'hEF, 1'b1, 1'b0);
    rst = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d required 0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b required 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b required 0", full); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_vld: got %b required 0", out_vld); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b required 0", ovf); end
`ifdef BUS_ELASTIC_OVF_CNT_EN
    checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_ovf_cnt: got %0d required 0", ovf_cnt); end
`endif
  endtask

  // Fill, drop, push+pop while full, then drain and check order.
  task automatic test_fill_drop();
    logic [W-1:0] got, req;
    in_vld = 1'b1; inbus = 8'h11; #1;
    checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL no_bypass: got %b required 0", out_vld); end
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    checks++; if (out_vld !== 1'b1 || outbus !== 8'h11) begin errors++; $display("[TB] FAIL latency_1: got vld=%b %h required vld=1 11", out_vld, outbus); end
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    checks++; if (full !== 1'b1 || level !== 3'd4) begin errors++; $display("[TB] FAIL fill_full: got full=%b level=%0d required full=1 level=4", full, level); end
    checks++; if (outbus !== 8'h11) begin errors++; $display("[TB] FAIL hold_head: got %h required 11", outbus); end
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    checks++; if (ovf !== 1'b1 || level !== 3'd4) begin errors++; $display("[TB] FAIL drop_ovf: got ovf=%b level=%0d required ovf=1 level=4", ovf, level); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b required 0", ovf); end
    cycle(1'b1, 8'h66, 1'b1, 1'b0);
    checks++; if (level !== 3'd4 || ovf !== 1'b0 || full !== 1'b1) begin errors++; $display("[TB] FAIL push_pop_full: got level=%0d ovf=%b full=%b required 4 0 1", level, ovf, full); end
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1 || out_vld !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty: got empty=%b vld=%b required 1 0", empty, out_vld); end
    while (expQ.size() > 0) begin
      req = expQ.pop_front();
      checks++;
      if (obsQ.size() == 0) begin errors++; $display("[TB] FAIL fill_order: got nothing required %h", req); end
      else begin
        got = obsQ.pop_front();
        if (got !== req) begin errors++; $display("[TB] FAIL fill_order: got %h required %h", got, req); end
      end
    end
    checks++; if (obsQ.size() != 0) begin errors++; $display("[TB] FAIL fill_extra: got %0d extra words required 0", obsQ.size()); obsQ.delete(); end
  endtask

  // Stream 0x01..0x0A with out_rdy toggling; pointers wrap past DEPTH.
  task automatic test_wrap();
    logic [W-1:0] got, req;
    int nextWord = 1;
    int seen = 0;
    for (int i = 0; i < 15; i++) begin
      if ((i % 3 != 2) && nextWord <= 10) begin
        cycle(1'b1, W'(nextWord), (i % 2 == 0), 1'b0);
        nextWord++;
      end else begin
        cycle(1'b0, 8'h00, (i % 2 == 0), 1'b0);
      end
      checks++; if (level > 3'd4 || int'(level) != mdlLevel) begin errors++; $display("[TB] FAIL wrap_level: got %0d required %0d", level, mdlLevel); end
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (ovf !== 1'b0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL wrap_no_drop: got ovf=%b empty=%b required 0 1", ovf, empty); end
    while (expQ.size() > 0) begin
      req = expQ.pop_front();
      checks++;
      if (obsQ.size() == 0) begin errors++; $display("[TB] FAIL wrap_order: got nothing required %h", req); end
      else begin
        got = obsQ.pop_front();
        seen++;
        if (got !== req) begin errors++; $display("[TB] FAIL wrap_order: got %h required %h", got, req); end
      end
    end
    checks++; if (seen != 10 || obsQ.size() != 0) begin errors++; $display("[TB] FAIL wrap_count: got %0d (+%0d extra) required 10", seen, obsQ.size()); obsQ.delete(); end
  endtask

  // A drop and a clear in the same cycle: the set wins.
  task automatic test_ovf_priority();
    for (int i = 0; i < 4; i++) cycle(1'b1, W'(8'hA0 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b0, 1'b1);
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set_wins: got %b required 1", ovf); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clr_alone: got %b required 0", ovf); end
  endtask

  // Three stored words and ovf set, then a one-cycle reset.
  task automatic test_reset_mid();
    logic [W-1:0] got, req;
    cycle(1'b1, 8'hBB, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (level !== 3'd3 || ovf !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset: got level=%0d ovf=%b required 3 1", level, ovf); end
    req = expQ.pop_front();
    checks++;
    if (obsQ.size() == 0) begin errors++; $display("[TB] FAIL pre_reset_pop: got nothing required %h", req); end
    else begin
      got = obsQ.pop_front();
      if (got !== req) begin errors++; $display("[TB] FAIL pre_reset_pop: got %h required %h", got, req); end
    end
    rst = 1'b1;
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    rst = 1'b0;
    checks++; if (level !== 3'd0 || out_vld !== 1'b0 || ovf !== 1'b0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset: got level=%0d vld=%b ovf=%b empty=%b required 0 0 0 1", level, out_vld, ovf, empty); end
    obsQ.delete();
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_ignores_in: got empty=%b required 1", empty); end
  endtask

`ifdef BUS_ELASTIC_OVF_CNT_EN
  // 300 drops saturate the counter; drop+clear loads 1; clear alone zeroes it.
  task automatic test_ovf_cnt();
    for (int i = 0; i < 4; i++) cycle(1'b1, W'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'hDD, 1'b0, 1'b0);
    checks++; if (ovf_cnt !== 8'd255) begin errors++; $display("[TB] FAIL ovf_cnt_sat: got %0d required 255", ovf_cnt); end
    cycle(1'b1, 8'hDD, 1'b0, 1'b1);
    checks++; if (ovf_cnt !== 8'd1) begin errors++; $display("[TB] FAIL ovf_cnt_drop_clr: got %0d required 1", ovf_cnt); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (ovf_cnt !== 8'd0 || int'(ovf_cnt) != mdlCnt) begin errors++; $display("[TB] FAIL ovf_cnt_clr: got %0d required 0", ovf_cnt); end
  endtask
`endif

  // Test sequence.
  initial begin
    rst = 1'b1; in_vld = 1'b0; inbus = '0; out_rdy = 1'b0; ovf_clr = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_fill_drop();
    test_wrap();
    test_ovf_priority();
    test_reset_mid();
`ifdef BUS_ELASTIC_OVF_CNT_EN
    test_ovf_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
